// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Constants and the next-PC source enumeration shared by the
//                fetch-side PC logic (pc_next_unit, pc_ras).
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int          PC_W         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
  localparam int          PC_STEP      = 4;

  // Listed lowest to highest priority.
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_RET    = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_BRANCH = 3'd4,
    SRC_EXC    = 3'd5
  } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack. A push onto a full stack
//                overwrites the oldest entry. Push and pop together replace
//                the top entry in place.
//  Revision    : 1.0  initial release
//  Ports       : clk, rst      clock, synchronous active-high reset
//                push, pop     stack operations (pop ignored when empty)
//                push_data     value pushed
//                top           most recently pushed live entry
//                empty, full   occupancy flags
// ============================================================================
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  import mips_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  // r_ptr is the next slot to write; when full this is also the oldest entry,
  // so a plain push naturally overwrites it.
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_pop;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CNT_W'(DEPTH));
  assign w_pop     = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (!full) r_cnt <= r_cnt + CNT_W'(1);
        end
        2'b01: begin
          r_ptr <= w_top_idx;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && w_pop)  r_mem[w_top_idx] <= push_data;
      else if (push)      r_mem[r_ptr]     <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Architectural PC register with fixed-priority next-address
//                selection (exception > branch > jr > jump > RAS return >
//                sequential), IF/ID flush pulse and return-address stack.
//  Revision    : 1.0  initial release
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                stall                     hold PC (exception still wins)
//                exc_req                   go to EXC_VECTOR
//                branch_taken/_target      taken branch redirect
//                jr_req/jr_target          jump-register redirect
//                jump_req/jump_target      J/JAL redirect
//                call                      push pc+4 onto the RAS
//                ret_req                   predicted return, pop the RAS
//                pc, pc_plus4              registered PC and pc+4
//                flush                     pulse after an accepted redirect
//                ras_empty, ras_full       RAS occupancy
//                ras_underflow             pulse after a return on empty RAS
// ============================================================================
module pc_next_unit #(
  parameter int            PC_W         = mips_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(mips_pkg::RESET_VECTOR),
  parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(mips_pkg::EXC_VECTOR),
  parameter int            RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            exc_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jr_req,
  input  logic [PC_W-1:0] jr_target,
  input  logic            jump_req,
  input  logic [PC_W-1:0] jump_target,
  input  logic            call,
  input  logic            ret_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);
  import mips_pkg::*;

  localparam logic [PC_W-1:0] c_STEP = PC_W'(PC_STEP);

  logic [PC_W-1:0] r_pc;
  logic            r_flush;
  logic            r_underflow;

  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_ras_top;
  pc_src_e         w_src;
  logic            w_blocked;
  logic            w_ret_miss;
  logic            w_push;
  logic            w_pop;

  assign w_pc_plus4 = r_pc + c_STEP;
  assign w_blocked  = stall & ~exc_req;

  always_comb begin
    w_src      = SRC_SEQ;
    w_target   = w_pc_plus4;
    w_ret_miss = 1'b0;
    if (exc_req) begin
      w_src    = SRC_EXC;
      w_target = EXC_VECTOR;
    end else if (!stall) begin
      if (branch_taken) begin
        w_src    = SRC_BRANCH;
        w_target = branch_target;
      end else if (jr_req) begin
        w_src    = SRC_JR;
        w_target = jr_target;
      end else if (jump_req) begin
        w_src    = SRC_JUMP;
        w_target = jump_target;
      end else if (ret_req) begin
        if (!ras_empty) begin
          w_src    = SRC_RET;
          w_target = w_ras_top;
        end else begin
          // Return predicted with nothing stacked: stay sequential.
          w_ret_miss = 1'b1;
        end
      end
    end
  end

  // Sequential flow keeps pc+4 as is; only redirect targets are word-aligned.
  assign w_next_pc = w_blocked         ? r_pc :
                     (w_src == SRC_SEQ) ? w_pc_plus4 :
                     {w_target[PC_W-1:2], 2'b00};

  assign w_pop  = (w_src == SRC_RET);
  assign w_push = call & ~stall & ~exc_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_VECTOR;
      r_flush     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_flush     <= (w_src != SRC_SEQ);
      r_underflow <= w_ret_miss;
    end
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign flush         = r_flush;
  assign ras_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_next_unit
//  Description : Self-checking bench for pc_next_unit: directed scenarios and
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_next_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, branch_taken, jr_req, jump_req, call, ret_req;
  logic [31:0] branch_target, jr_target, jump_target;
  logic [31:0] pc, pc_plus4;
  logic        flush, ras_empty, ras_full, ras_underflow;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_flush, m_uf;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_next_unit #(
    .PC_W         (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080),
    .RAS_DEPTH    (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .exc_req       (exc_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr_req        (jr_req),
    .jr_target     (jr_target),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .call          (call),
    .ret_req       (ret_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .flush         (flush),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] t);
    logic [31:0] r;
    r = t & 32'hFFFF_FFFC;
    return r;
  endfunction

  // Compare every cycle against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",            pc,            m_pc);
      check("pc_plus4",      pc_plus4,      m_pc + 32'd4);
      check("flush",         32'(flush),    32'(m_flush));
      check("ras_empty",     32'(ras_empty),32'(m_ras.size() == 0));
      check("ras_full",      32'(ras_full), 32'(m_ras.size() == D));
      check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
    end
  end

  task automatic idle();
    rst = 0; stall = 0; exc_req = 0; branch_taken = 0; jr_req = 0; jump_req = 0;
    call = 0; ret_req = 0; branch_target = 0; jr_target = 0; jump_target = 0;
  endtask

  // Advance one clock: the model's next state is computed from the inputs
  // presented now, then committed right at the edge.
  task automatic tick();
    logic [31:0] n_pc, tgt;
    logic [31:0] n_ras[$];
    bit n_flush, n_uf, blocked, pop;
    n_ras = m_ras;
    if (rst) begin
      n_pc = 32'h0; n_flush = 0; n_uf = 0; n_ras.delete();
    end else begin
      blocked = stall && !exc_req;
      n_flush = 0; n_uf = 0; pop = 0; tgt = 32'h0;
      if (exc_req) begin n_flush = 1; tgt = 32'h80; end
      else if (!blocked) begin
        if (branch_taken)  begin n_flush = 1; tgt = branch_target; end
        else if (jr_req)   begin n_flush = 1; tgt = jr_target; end
        else if (jump_req) begin n_flush = 1; tgt = jump_target; end
        else if (ret_req) begin
          if (m_ras.size() > 0) begin n_flush = 1; tgt = m_ras[$]; pop = 1; end
          else n_uf = 1;
        end
      end
      n_pc = blocked ? m_pc : (n_flush ? align(tgt) : m_pc + 32'd4);
      if (!exc_req && !blocked) begin
        if (pop) void'(n_ras.pop_back());
        if (call) begin
          n_ras.push_back(m_pc + 32'd4);
          if (n_ras.size() > D) void'(n_ras.pop_front());
        end
      end
    end
    @(posedge clk);
    m_pc = n_pc; m_flush = n_flush; m_uf = n_uf; m_ras = n_ras;
    if (rst) chk_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    idle();
    do_reset();

    // Free-running from reset.
    check("reset_pc", pc, 32'h0);
    check("reset_flush", 32'(flush), 32'h0);
    tick(); check("seq_pc1", pc, 32'h4);
    tick(); check("seq_pc2", pc, 32'h8);
    tick(); check("seq_pc3", pc, 32'hC);
    check("seq_flush", 32'(flush), 32'h0);

    // Branch beats jump.
    branch_taken = 1; branch_target = 32'h100; jump_req = 1; jump_target = 32'h200;
    tick(); idle();
    check("br_pc", pc, 32'h100);
    check("br_flush", 32'(flush), 32'h1);

    // Stalled JR held, then taken with LSBs masked.
    stall = 1; jr_req = 1; jr_target = 32'h101;
    tick(); check("stall_pc1", pc, 32'h100);
    tick(); check("stall_pc2", pc, 32'h100);
    check("stall_flush", 32'(flush), 32'h0);
    stall = 0;
    tick(); idle();
    check("jr_pc", pc, 32'h100);
    check("jr_flush", 32'(flush), 32'h1);

    // Exception overrides stall and leaves the RAS alone.
    do_reset();
    call = 1; jump_req = 1; jump_target = 32'h40;
    tick(); idle();
    check("call_jmp_pc", pc, 32'h40);
    stall = 1; exc_req = 1; call = 1; ret_req = 1;
    tick(); idle();
    check("exc_pc", pc, 32'h80);
    check("exc_flush", 32'(flush), 32'h1);
    check("exc_ras_nonempty", 32'(ras_empty), 32'h0);
    ret_req = 1;
    tick(); idle();
    check("exc_ras_top", pc, 32'h4);

    // Fill past depth, drain, then underflow.
    do_reset();
    jump_req = 1; jump_target = 32'h10;
    tick();
    for (int i = 1; i <= 5; i++) begin
      call = 1; jump_req = 1; jump_target = 32'(16 * (i + 1));
      tick();
    end
    idle();
    check("ras_full_after5", 32'(ras_full), 32'h1);
    ret_req = 1;
    tick(); check("pop1", pc, 32'h54);
    tick(); check("pop2", pc, 32'h44);
    tick(); check("pop3", pc, 32'h34);
    tick(); check("pop4", pc, 32'h24);
    tick(); idle();
    check("uf_pc", pc, 32'h28);
    check("uf_pulse", 32'(ras_underflow), 32'h1);
    check("uf_empty", 32'(ras_empty), 32'h1);
    check("uf_noflush", 32'(flush), 32'h0);
    tick();
    check("uf_pulse_end", 32'(ras_underflow), 32'h0);

    // Call and return together replace the top.
    do_reset();
    jump_req = 1; jump_target = 32'h30; tick();
    call = 1; jump_target = 32'h60; tick(); idle();
    call = 1; ret_req = 1; tick(); idle();
    check("callret_pc", pc, 32'h34);
    ret_req = 1; tick(); idle();
    check("callret_top", pc, 32'h64);
    check("callret_empty", 32'(ras_empty), 32'h1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      exc_req       = ($urandom_range(0, 15) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jr_req        = ($urandom_range(0, 9) == 0);
      jump_req      = ($urandom_range(0, 9) == 0);
      call          = ($urandom_range(0, 2) == 0);
      ret_req       = ($urandom_range(0, 2) == 0);
      branch_target = $urandom;
      jr_target     = $urandom;
      jump_target   = $urandom;
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
